// File: rtl/signed_mult_pipe.sv
// rtl/signed_mult_pipe.sv - pipelined signed multiplier with valid/ready handshake and pass-through tag
// Define SIGNED_MULT_ROUND_EN to round the rescaled magnitude half away from zero instead of truncating.
module signed_mult_pipe #(
    parameter int W         = 16,
    parameter int FRAC_BITS = 0,
    parameter int LATENCY   = 4,
    parameter int TAG_W     = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int NP = LATENCY - 2;
    localparam int PW = 2 * W;
`ifdef SIGNED_MULT_ROUND_EN
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic [PW-1:0] RND_INC = (FRAC_BITS > 0) ? (PW'(1) << RND_SH) : '0;
`else
    localparam logic [PW-1:0] RND_INC = '0;
`endif

    logic             adv;
    logic [W-1:0]     mag_a_d, mag_b_d;
    logic [W-1:0]     mag_a_q, mag_b_q;
    logic             sign_q;
    logic [TAG_W-1:0] tag_q;
    logic             s1_valid_q;

    logic [PW-1:0]    prod_q       [NP];
    logic             prod_sign_q  [NP];
    logic [TAG_W-1:0] prod_tag_q   [NP];
    logic             prod_valid_q [NP];

    logic [PW-1:0]    prod_d, mag_rnd, mag_shr, out_p_d;
    logic             out_valid_q;
    logic [PW-1:0]    out_p_q;
    logic [TAG_W-1:0] out_tag_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;

    // Magnitudes are W-bit unsigned, so |-2^(W-1)| = 2^(W-1) is represented exactly.
    always_comb begin
        mag_a_d = in_a[W-1] ? (~in_a + 1'b1) : in_a;
        mag_b_d = in_b[W-1] ? (~in_b + 1'b1) : in_b;
        prod_d  = {{W{1'b0}}, mag_a_q} * {{W{1'b0}}, mag_b_q};
        mag_rnd = prod_q[NP-1] + RND_INC;
        mag_shr = mag_rnd >> FRAC_BITS;
        out_p_d = prod_sign_q[NP-1] ? (~mag_shr + 1'b1) : mag_shr;
    end

    always_comb begin
        busy = s1_valid_q | out_valid_q;
        for (int k = 0; k < NP; k++) begin
            busy = busy | prod_valid_q[k];
        end
    end

    // The product is formed once and then carried through the remaining stages so retiming can spread it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            sign_q      <= 1'b0;
            tag_q       <= '0;
            s1_valid_q  <= 1'b0;
            for (int k = 0; k < NP; k++) begin
                prod_q[k]       <= '0;
                prod_sign_q[k]  <= 1'b0;
                prod_tag_q[k]   <= '0;
                prod_valid_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            mag_a_q         <= mag_a_d;
            mag_b_q         <= mag_b_d;
            sign_q          <= in_a[W-1] ^ in_b[W-1];
            tag_q           <= in_tag;
            s1_valid_q      <= in_valid;
            prod_q[0]       <= prod_d;
            prod_sign_q[0]  <= sign_q;
            prod_tag_q[0]   <= tag_q;
            prod_valid_q[0] <= s1_valid_q;
            for (int k = 1; k < NP; k++) begin
                prod_q[k]       <= prod_q[k-1];
                prod_sign_q[k]  <= prod_sign_q[k-1];
                prod_tag_q[k]   <= prod_tag_q[k-1];
                prod_valid_q[k] <= prod_valid_q[k-1];
            end
            out_valid_q <= prod_valid_q[NP-1];
            if (prod_valid_q[NP-1]) begin
                out_p_q   <= out_p_d;
                out_tag_q <= prod_tag_q[NP-1];
            end
        end
    end

endmodule

// File: tb/tb_signed_mult_pipe.sv
// tb/tb_signed_mult_pipe.sv - self-checking bench for signed_mult_pipe (FRAC_BITS 0 and 8 instances)
module tb_signed_mult_pipe;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic [3:0]  tag = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_p;
    logic [3:0]  out_tag;
    logic        in_ready8, out_valid8, busy8;
    logic [31:0] out_p8;
    logic [3:0]  out_tag8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    signed_mult_pipe #(.W(16), .FRAC_BITS(0), .LATENCY(L), .TAG_W(4)) u_dut (
        .CLK(clk), .RST_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(a), .in_b(b), .in_tag(tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .busy(busy)
    );

    signed_mult_pipe #(.W(16), .FRAC_BITS(8), .LATENCY(L), .TAG_W(4)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(a), .in_b(b), .in_tag(tag), .out_valid(out_valid8), .out_ready(out_ready),
        .out_p(out_p8), .out_tag(out_tag8), .busy(busy8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [31:0] p0;
        logic [31:0] p8;
    } vec_t;

    typedef struct {
        logic [31:0] p0;
        logic [31:0] p8;
        logic [3:0]  tag;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input int f);
        longint p, m;
        p = longint'($signed(x)) * longint'($signed(y));
        m = (p < 0) ? -p : p;
`ifdef SIGNED_MULT_ROUND_EN
        if (f > 0) m = m + (longint'(1) << (f - 1));
`endif
        m = m >> f;
        if (p < 0) m = -m;
        return 32'(m);
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic single(input vec_t v, input string nm);
        @(negedge clk);
        a = v.a; b = v.b; tag = v.tag; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, ".in_ready"}, in_ready, 1);
        check({nm, ".in_ready8"}, in_ready8, 1);
        for (int e = 1; e <= L + 1; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (e == L) begin
                check({nm, ".valid"}, out_valid, 1);
                check({nm, ".p0"}, out_p, v.p0);
                check({nm, ".tag"}, out_tag, v.tag);
                check({nm, ".valid8"}, out_valid8, 1);
                check({nm, ".p8"}, out_p8, v.p8);
                check({nm, ".tag8"}, out_tag8, v.tag);
            end else begin
                check({nm, ".no_valid"}, out_valid, 0);
            end
        end
    endtask

    task automatic run_stream(input int n, input bit rnd, input string nm);
        exp_t        q[$];
        exp_t        e;
        int          sent = 0, got = 0, cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] hold_p = '0, hold_p8 = '0;
        logic [3:0]  hold_t = '0;
        logic [15:0] na, nb;
        na = rnd ? rand_op() : 16'(16'h0101 * 3 - 700);
        nb = rnd ? rand_op() : 16'hFFF3;
        while (got < n && cyc < 20 * n + 100) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check({nm, ".hold_valid"}, out_valid, 1);
                check({nm, ".hold_p"}, out_p, hold_p);
                check({nm, ".hold_p8"}, out_p8, hold_p8);
                check({nm, ".hold_tag"}, out_tag, hold_t);
            end
            if (sent < n) begin
                in_valid = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
                a = na; b = nb;
                tag = rnd ? 4'($urandom) : 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(cyc >= 6 && cyc <= 8);
            #1;
            if (!rnd && cyc >= 6 && cyc <= 8) check({nm, ".in_ready_low"}, in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({nm, ".spurious"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check({nm, ".p0"}, out_p, e.p0);
                    check({nm, ".p8"}, out_p8, e.p8);
                    check({nm, ".tag"}, out_tag, e.tag);
                    check({nm, ".valid8"}, out_valid8, 1);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back('{ref_mul(a, b, 0), ref_mul(a, b, 8), tag});
                sent++;
                na = rnd ? rand_op() : 16'(na * 7 + 16'h3001);
                nb = rnd ? rand_op() : 16'(nb + 16'h1235);
            end
            stalled = out_valid && !out_ready;
            hold_p = out_p; hold_p8 = out_p8; hold_t = out_tag;
        end
        check({nm, ".count"}, got, n);
        check({nm, ".leftover"}, q.size(), 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'hFFFD, 16'h0005, 4'd2,  32'hFFFF_FFF1, 32'h0000_0000};
        vecs[1] = '{16'h8000, 16'h8000, 4'd5,  32'h4000_0000, 32'h0040_0000};
        vecs[2] = '{16'h7FFF, 16'h8000, 4'd9,  32'hC000_8000, 32'hFFC0_0080};
        vecs[3] = '{16'h0180, 16'hFF80, 4'd12, 32'hFFFF_4000, 32'hFFFF_FF40};
`ifdef SIGNED_MULT_ROUND_EN
        vecs[4] = '{16'h0003, 16'hFFD5, 4'd15, 32'hFFFF_FF7F, 32'hFFFF_FFFF};
`else
        vecs[4] = '{16'h0003, 16'hFFD5, 4'd15, 32'hFFFF_FF7F, 32'h0000_0000};
`endif
        vecs[5] = '{16'h0000, 16'h8000, 4'd7,  32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 4'd1,  32'h3FFF_0001, 32'h003F_FF00};

        repeat (3) @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.out_p", out_p, 0);
        check("rst.out_tag", out_tag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.idle", busy, 0);

        for (int i = 0; i < 7; i++) single(vecs[i], $sformatf("vec%0d", i));

        run_stream(8, 1'b0, "stall");

        // Fill the pipe with the output stalled, then reset asynchronously mid-cycle.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(i + 2); b = 16'hFFF0; tag = 4'(i + 8);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("inflight.busy", busy, 1);
        check("inflight.valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", out_valid, 0);
        check("arst.busy", busy, 0);
        check("arst.busy8", busy8, 0);
        check("arst.out_p", out_p, 0);
        check("arst.out_tag", out_tag, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        single(vecs[2], "post_rst");

        run_stream(10000, 1'b1, "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
